// File: rtl/bias_layer_seq_if.sv
// bias_layer_seq_if
//   Groups the layer sequencer's memory read bus and result handshake.
//   master : sequencer side (drives addresses and the result stream)
//   slave  : memory bank / consumer side
//   Signals:
//     pix_addr/pix_data    pixel memory address and combinational read data
//     w_addr/w_data        weight memory address and combinational read data
//     bias_addr/bias_data  bias file address and combinational read data
//     out_valid/out_ready  result handshake
//     out_data/out_idx     saturated result and its neuron index
interface bias_layer_seq_if #(
  parameter int DATA_W  = 16,
  parameter int IADDR_W = 10,
  parameter int WADDR_W = 14,
  parameter int BADDR_W = 8
);
  logic [IADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0]  pix_data;
  logic [WADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]  w_data;
  logic [BADDR_W-1:0] bias_addr;
  logic [DATA_W-1:0]  bias_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [BADDR_W-1:0] out_idx;

  modport master (
    output pix_addr, w_addr, bias_addr, out_valid, out_data, out_idx,
    input  pix_data, w_data, bias_data, out_ready
  );

  modport slave (
    input  pix_addr, w_addr, bias_addr, out_valid, out_data, out_idx,
    output pix_data, w_data, bias_data, out_ready
  );
endinterface

// File: rtl/bias_layer_seq.sv
// bias_layer_seq
//   Sequences one fully connected MLP layer: for each neuron it accumulates
//   N_IN pixel*weight products (one per cycle), adds the neuron's bias after
//   dropping FRAC fraction bits, saturates to signed DATA_W and hands the
//   result out over a valid/ready handshake.
//   Optional build macro: BIAS_LAYER_RELU_EN -- applies ReLU after saturation.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     start  pulse, starts a layer pass when idle (ignored otherwise)
//     bus    bias_layer_seq_if.master: memory addresses/data and result stream
//     busy   high in any state except IDLE
//     done   one-cycle pulse after the last neuron's result is accepted
module bias_layer_seq #(
  parameter int N_IN     = 784,
  parameter int N_NEURON = 15,
  parameter int DATA_W   = 16,
  parameter int FRAC     = 8,
  parameter int ACC_W    = 40,
  parameter int IADDR_W  = 10,
  parameter int WADDR_W  = 14,
  parameter int BADDR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  bias_layer_seq_if.master bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_OUT
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t state_q, state_d;

  logic [IADDR_W-1:0]       i_q;
  logic [WADDR_W-1:0]       wcnt_q;
  logic [BADDR_W-1:0]       neuron_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        out_data_q;
  logic [BADDR_W-1:0]       out_idx_q;
  logic                     out_valid_q;
  logic                     done_q;

  logic                       last_in;
  logic                       last_neuron;
  logic                       xfer;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]          result;

  assign last_in     = (i_q == IADDR_W'(N_IN - 1));
  assign last_neuron = (neuron_q == BADDR_W'(N_NEURON - 1));
  assign xfer        = out_valid_q && bus.out_ready;

  // Full-width signed product, sign-extended into the accumulator width.
  assign prod     = $signed(bus.pix_data) * $signed(bus.w_data);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){bus.bias_data[DATA_W-1]}}, bus.bias_data};
  assign sum      = (acc_q >>> FRAC) + bias_ext;

  always_comb begin
    result = sum[DATA_W-1:0];
    if (sum > SAT_MAX) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end
`ifdef BIAS_LAYER_RELU_EN
    if (result[DATA_W-1]) begin
      result = '0;
    end
`else
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)   state_d = S_MAC;
      S_MAC:  if (last_in) state_d = S_BIAS;
      S_BIAS: state_d = S_OUT;
      S_OUT:  if (xfer)    state_d = last_neuron ? S_IDLE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: counters, accumulator and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q         <= '0;
      wcnt_q      <= '0;
      neuron_q    <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q    <= '0;
            i_q      <= '0;
            wcnt_q   <= '0;
            neuron_q <= '0;
          end
        end
        S_MAC: begin
          acc_q  <= acc_q + prod_ext;
          i_q    <= i_q + IADDR_W'(1);
          // Weight counter runs on across neurons: neuron n starts at n*N_IN.
          wcnt_q <= wcnt_q + WADDR_W'(1);
        end
        S_BIAS: begin
          out_data_q  <= result;
          out_idx_q   <= neuron_q;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            i_q         <= '0;
            if (last_neuron) begin
              done_q <= 1'b1;
            end else begin
              neuron_q <= neuron_q + BADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign bus.pix_addr  = busy ? i_q      : '0;
  assign bus.w_addr    = busy ? wcnt_q   : '0;
  assign bus.bias_addr = busy ? neuron_q : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

endmodule

// File: doc/bias_layer_seq.md
Name: bias_layer_seq

Overview:
- Sequences one fully connected MLP layer over a bank of combinational-read memories: pixel/activation memory, weight memory and bias register file.
- For each neuron it accumulates N_IN products, adds that neuron's bias, saturates, and emits one result over a valid/ready handshake.
- Sits between the layer memories and the next layer's activation buffer.

Parameters:
- N_IN, 784: inputs per neuron.
- N_NEURON, 15: neurons in the layer, which is also the bias file depth.
- DATA_W, 16: signed fixed-point width of pixel, weight, bias and result (Q8.8).
- FRAC, 8: fractional bits.
- ACC_W, 40: signed accumulator width.
- IADDR_W, 10: pixel address width.
- WADDR_W, 14: weight address width.
- BADDR_W, 8: bias address width.

Ports:
- clk  in  1  rising-edge clock, the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; starts a layer pass when idle.
- pix_addr  out  IADDR_W  pixel memory address.
- pix_data  in  DATA_W  pixel read data, combinational from pix_addr.
- w_addr  out  WADDR_W  weight address, equal to neuron*N_IN + i.
- w_data  in  DATA_W  weight read data, combinational.
- bias_addr  out  BADDR_W  bias file address, equal to the neuron index.
- bias_data  in  DATA_W  bias read data, combinational.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  saturated neuron result.
- out_idx  out  BADDR_W  neuron index of out_data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last neuron is accepted.

Behaviour:
- Reset (synchronous, active-high) values:
  - State goes to IDLE.
  - All counters and the accumulator clear to 0.
  - All address outputs read 0.
  - out_valid, out_data, out_idx, busy and done all read 0.
  - Reset overrides any state, including mid-MAC or during an OUT stall. No result is emitted after reset.
- IDLE:
  - On start=1, clear the accumulator, set neuron=0, i=0, w_addr=0, and go to MAC.
  - start is ignored in every other state.
- MAC, one product per cycle:
  - Drive pix_addr=i and w_addr to the running weight counter.
  - acc <= acc + sign_extend(pix_data*w_data), where the product is a 2*DATA_W signed value.
  - i and w_addr both increment by 1 each cycle.
  - On the cycle with i==N_IN-1, go to BIAS. The weight counter continues without reset, so neuron n+1 starts at (n+1)*N_IN.
  - MAC takes exactly N_IN cycles per neuron.
- BIAS, one cycle:
  - bias_addr = neuron.
  - sum = (acc >>> FRAC) + sign_extend(bias_data), using an arithmetic shift.
  - Saturate sum to the signed DATA_W range, 0x7FFF..0x8000.
  - Register the result into out_data, set out_idx=neuron and out_valid=1, and go to OUT.
- OUT:
  - out_data and out_idx hold stable while out_valid=1 and out_ready=0.
  - Transfer happens on the cycle with out_valid && out_ready. On that cycle out_valid drops, the accumulator clears and i resets to 0.
  - If neuron==N_NEURON-1: pulse done for one cycle and go to IDLE.
  - Otherwise: neuron+1 and go to MAC.
- Latency: with out_ready held high, each neuron takes N_IN+2 cycles and the full layer takes N_NEURON*(N_IN+2) cycles.
- Accumulator overflow wraps at ACC_W; the ACC_W default is sized so it cannot overflow for N_IN ≤ 2^8.
- bias_addr holds the neuron index in every non-IDLE state.
- Addresses are don't-care in IDLE but are driven to 0.

Optional Feature:
- Macro: BIAS_LAYER_RELU_EN.
- When defined, BIAS applies ReLU after saturation: any negative result becomes 0x0000.
- When not defined, signed saturated results pass through unchanged.
- Timing and handshake are identical in both cases.

Test Plan:
- Basic pass, N_IN=4, N_NEURON=3, all pixels 0x0100 (1.0), weights 0x0100, biases 0x0080 (0.5), out_ready=1 -> results 0x0480 three times, out_idx 0,1,2, done pulses once at cycle 18 after start.
- Address walk -> w_addr runs 0..11 contiguously across neurons; pix_addr runs 0..3 repeating; bias_addr equals the neuron index.
- Saturation, all pixels 0x7FFF and weights 0x7FFF -> out_data=0x7FFF. All weights 0x8001 with positive pixels -> 0x8000 without BIAS_LAYER_RELU_EN, 0x0000 with it.
- Backpressure: out_ready=0 for 5 cycles on neuron 1 -> out_valid stays 1 and out_data/out_idx stay stable; the next neuron's MAC starts only after the transfer; total cycle count grows by exactly 5.
- Reset mid-operation, during MAC of neuron 1 and again during an OUT stall -> all outputs 0 in the following cycle, busy=0, no done. A new start then gives the full correct sequence from neuron 0.
- start asserted while busy -> ignored; results and timing identical to a single start.
